freq_word_gen: RTL
==================

FREQ_WORD_GEN -- requirements
Module: freq_word_gen

Interface
REQ-001 Parameter NUM_CH, default 32: number of valid channels, 2..2^CH_W.
REQ-002 Parameter CH_W, default 6: channel number width.
REQ-003 Parameter FRAC_W, default 4: fractional field width, 1..8.
REQ-004 Parameter STEP_FRAC, default 3: per-channel step, in fractional LSBs.
REQ-005 Parameter BASE_INT, default 8'h3C: integer field for channel 0.
REQ-006 Parameter BASE_FRAC, default 0: fractional field for channel 0, < 2^FRAC_W.
REQ-007 Parameters HI_PREFIX 8'h0C and LO_PREFIX 8'h0D: fixed register-address bytes.
REQ-008 Parameter DWELL_W, default 16: width of the dwell counter.
REQ-009 clk  in  1  sole clock; all logic on the rising edge.
REQ-010 rst  in  1  synchronous, active-high reset.
REQ-011 ch_req_valid  in  1  manual channel request.
REQ-012 ch_req_num  in  CH_W  requested channel.
REQ-013 ch_req_ready  out  1  request accepted when valid&ready at a rising edge.
REQ-014 hop_en  in  1  enables automatic channel hopping.
REQ-015 dwell_cycles  in  DWELL_W  idle cycles between hops; 0 is treated as 1.
REQ-016 word_data  out  32  register word for the radio SPI writer.
REQ-017 word_valid  out  1  word_data is valid.
REQ-018 word_ready  in  1  downstream accepts the word.
REQ-019 cur_ch  out  CH_W  channel of the most recently accepted request or hop.
REQ-020 busy  out  1  high whenever state is not IDLE.
REQ-021 ch_err  out  1  one-cycle pulse when an out-of-range request is accepted.

Function
REQ-022 The block SHALL have four states: IDLE, CALC1, CALC2 and OUT; ch_req_ready = (state==IDLE); busy = (state!=IDLE).
REQ-023 IDLE: on an accepted manual request, or on a hop event, the block SHALL latch the channel into cur_ch and go to CALC1.
REQ-024 CALC1: the block SHALL register acc = cur_ch*STEP_FRAC + BASE_FRAC, unsigned, wide enough to be lossless, then go to CALC2.
REQ-025 CALC2: the block SHALL register word_data = {HI_PREFIX, frac<<(8-FRAC_W), LO_PREFIX, (BASE_INT + (acc>>FRAC_W)) mod 256}, where frac = acc mod 2^FRAC_W; it SHALL then go to OUT.
REQ-026 Latency: an accept at rising edge k SHALL give word_valid=1 during the cycle after edge k+2.
REQ-027 OUT: word_valid SHALL be 1 and word_data SHALL stay stable until word_valid&word_ready; that edge SHALL return the block to IDLE with word_valid=0.
REQ-028 Out-of-range request (ch_req_num >= NUM_CH): the block SHALL substitute channel 0 and pulse ch_err in the cycle after the accept.
REQ-029 Dwell counter: it SHALL increment each IDLE cycle while hop_en=1, and clear on any IDLE exit and whenever hop_en=0.
REQ-030 Hop event: in IDLE with hop_en=1 and counter = max(dwell_cycles,1)-1, the next channel SHALL be cur_ch+1, wrapping from NUM_CH-1 to 0.
REQ-031 Simultaneous manual request and hop event: the manual request SHALL win and the hop SHALL be discarded, with the counter cleared.
REQ-032 Requests and hops SHALL NOT be queued while busy; the dwell counter SHALL hold at 0 outside IDLE.
REQ-033 The accumulator integer carry SHALL wrap modulo 256 in the integer byte without error.

Reset
REQ-034 While rst=1 at an edge, the block SHALL enter IDLE with word_valid=0, word_data=0, cur_ch=0, ch_err=0 and the dwell counter at 0.
REQ-035 Reset asserted in any state SHALL abort the operation; the in-flight word SHALL be discarded and never presented.
REQ-036 Leaving reset SHALL NOT emit a word by itself; the first word requires a request or a hop.

Verification
REQ-037 Manual request for ch 1, word_ready=1 -> word_data 32'h0C300D3C, valid 3 cycles after accept, then IDLE.
REQ-038 Manual requests for ch 6 and ch 31 -> 32'h0C200D3D and 32'h0CD00D41 respectively.
REQ-039 Request for ch 40 -> ch_err pulse, cur_ch=0, word 32'h0C000D3C.
REQ-040 hop_en=1, dwell_cycles=4, starting at cur_ch=31 -> next word is for ch 0, issued after exactly 4 IDLE cycles.
REQ-041 word_ready held 0 for 10 cycles -> word_data stable and ch_req_ready=0 throughout; a manual request in that window is not accepted.
REQ-042 rst pulsed during CALC2 -> word_valid is never asserted, and a request issued after reset behaves exactly as in the ch 1 scenario.

Source files
------------

// File: rtl/freq_word_gen_if.sv
// freq_word_gen_if
// Purpose : bundles the channel-request and register-word handshakes of
//           freq_word_gen so they can be passed around as a single port.
// Signals : ch_req_valid / ch_req_num / ch_req_ready -- channel request
//           word_data / word_valid / word_ready       -- word to SPI writer
// Handshake rule (both channels): a transfer happens on a rising edge where
// valid and ready are both 1. A source holding valid keeps its payload
// stable until that edge. The sink may drop or raise ready freely.
// Modports: slave  = freq_word_gen side (takes requests, sources words)
//           master = requester / word-consumer side
interface freq_word_gen_if #(
    parameter int CH_W = 6
) ();
    logic            ch_req_valid;
    logic [CH_W-1:0] ch_req_num;
    logic            ch_req_ready;
    logic [31:0]     word_data;
    logic            word_valid;
    logic            word_ready;

    modport slave (
        input  ch_req_valid, ch_req_num, word_ready,
        output ch_req_ready, word_data, word_valid
    );

    modport master (
        output ch_req_valid, ch_req_num, word_ready,
        input  ch_req_ready, word_data, word_valid
    );
endinterface

// File: rtl/freq_word_gen.sv
// freq_word_gen
// Purpose : turns a radio channel number into a 32-bit register word
//           {HI_PREFIX, frac_byte, LO_PREFIX, int_byte} for an SPI writer.
//           Channels come from manual requests or from automatic hopping
//           after a programmable dwell time in IDLE.
// Ports   : clk, rst      -- clock, synchronous active-high reset
//           bus (slave)   -- channel request and word handshakes
//           hop_en        -- enable automatic hopping
//           dwell_cycles  -- IDLE cycles between hops (0 behaves as 1)
//           cur_ch        -- channel of the last accepted request or hop
//           busy          -- state is not IDLE
//           ch_err        -- one-cycle pulse after an out-of-range request
//           state_dbg     -- raw FSM state for observation
module freq_word_gen #(
    parameter int         NUM_CH    = 32,
    parameter int         CH_W      = 6,
    parameter int         FRAC_W    = 4,
    parameter int         STEP_FRAC = 3,
    parameter logic [7:0] BASE_INT  = 8'h3C,
    parameter int         BASE_FRAC = 0,
    parameter logic [7:0] HI_PREFIX = 8'h0C,
    parameter logic [7:0] LO_PREFIX = 8'h0D,
    parameter int         DWELL_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    freq_word_gen_if.slave     bus,
    input  logic               hop_en,
    input  logic [DWELL_W-1:0] dwell_cycles,
    output logic [CH_W-1:0]    cur_ch,
    output logic               busy,
    output logic               ch_err,
    output logic [1:0]         state_dbg
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CALC1 = 2'd1;
    localparam logic [1:0] CALC2 = 2'd2;
    localparam logic [1:0] OUT   = 2'd3;

    // Lossless width for cur_ch*STEP_FRAC + BASE_FRAC (BASE_FRAC < 2^FRAC_W).
    localparam int STEP_W = $clog2(STEP_FRAC + 1);
    localparam int ACC_W  = CH_W + STEP_W + FRAC_W + 1;

    logic [1:0]         state;
    logic [ACC_W-1:0]   acc;
    logic [31:0]        word_data;
    logic               word_valid;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [DWELL_W-1:0] dwell_target;
    logic               req_acc;
    logic               req_bad;
    logic               hop_evt;
    logic [CH_W-1:0]    next_ch;
    logic [7:0]         frac_byte;
    logic [7:0]         int_byte;

    assign bus.ch_req_ready = (state == IDLE);
    assign bus.word_data    = word_data;
    assign bus.word_valid   = word_valid;
    assign busy             = (state != IDLE);
    assign state_dbg        = state;

    assign req_acc = bus.ch_req_valid && (state == IDLE);
    // Extra bit so NUM_CH == 2^CH_W still compares correctly.
    assign req_bad = ({1'b0, bus.ch_req_num} >= (CH_W+1)'(NUM_CH));

    // A dwell of 0 is treated as 1, i.e. hop on the first IDLE cycle.
    assign dwell_target = (dwell_cycles == '0) ? '0 : dwell_cycles - 1'b1;
    assign hop_evt      = (state == IDLE) && hop_en && (dwell_cnt == dwell_target);
    assign next_ch      = (cur_ch == CH_W'(NUM_CH - 1)) ? '0 : cur_ch + 1'b1;

    // Fraction is left-aligned in its byte; integer part wraps mod 256.
    assign frac_byte = 8'(acc[FRAC_W-1:0]) << (8 - FRAC_W);
    assign int_byte  = BASE_INT + 8'(acc >> FRAC_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cur_ch     <= '0;
            acc        <= '0;
            word_data  <= '0;
            word_valid <= 1'b0;
            ch_err     <= 1'b0;
            dwell_cnt  <= '0;
        end else begin
            ch_err <= 1'b0;
            case (state)
                IDLE: begin
                    // Manual request outranks a coincident hop event.
                    if (req_acc) begin
                        cur_ch    <= req_bad ? '0 : bus.ch_req_num;
                        ch_err    <= req_bad;
                        dwell_cnt <= '0;
                        state     <= CALC1;
                    end else if (hop_evt) begin
                        cur_ch    <= next_ch;
                        dwell_cnt <= '0;
                        state     <= CALC1;
                    end else if (hop_en) begin
                        dwell_cnt <= dwell_cnt + 1'b1;
                    end else begin
                        dwell_cnt <= '0;
                    end
                end
                CALC1: begin
                    acc   <= ACC_W'(cur_ch) * ACC_W'(STEP_FRAC) + ACC_W'(BASE_FRAC);
                    state <= CALC2;
                end
                CALC2: begin
                    word_data  <= {HI_PREFIX, frac_byte, LO_PREFIX, int_byte};
                    word_valid <= 1'b1;
                    state      <= OUT;
                end
                OUT: begin
                    if (bus.word_ready) begin
                        word_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
